// File: rtl/mem_stage_sram_pkg.sv
// Shared types and defaults for the MEM stage with external SRAM.
// Holds the access FSM encoding and the default geometry parameters.
package mem_stage_sram_pkg;

  localparam int SRAM_WAIT_DEF = 2;
  localparam int BASE_ADDR_DEF = 1024;
  localparam int SRAM_AW_DEF   = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_stage_sram_if.sv
// Pin bundle of the external 16-bit single-port SRAM.
// master: MEM stage drives addr/data/oe/we_n; slave: SRAM returns dq_in.
interface mem_stage_sram_if #(
  parameter int AW = 18
);

  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;

  modport master (
    output sram_addr,
    output sram_dq_out,
    output sram_dq_oe,
    output sram_we_n,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr,
    input  sram_dq_out,
    input  sram_dq_oe,
    input  sram_we_n,
    output sram_dq_in
  );

endinterface

// File: rtl/mem_sram_fsm.sv
// SRAM access sequencer: low then high half-word, SRAM_WAIT cycles each.
// Ports: req/rd/wr/addresses/wdata in; rdata {hi,lo}, done flag, SRAM pins.
module mem_sram_fsm
  import mem_stage_sram_pkg::*;
#(
  parameter int SRAM_WAIT = SRAM_WAIT_DEF,
  parameter int SRAM_AW   = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               rd,
  input  logic               wr,
  input  logic [SRAM_AW-1:0] lo_addr,
  input  logic [SRAM_AW-1:0] hi_addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               done,
  mem_stage_sram_if.master   sram
);

  localparam int CW = $clog2(SRAM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(SRAM_WAIT - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [15:0]   lo;
  logic [15:0]   hi;
  logic          last;
  logic          acc;

  assign last  = (cnt == LAST);
  assign acc   = (state == ACC_LO) || (state == ACC_HI);
  assign rdata = {hi, lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      state <= state_nx;
      if (acc && !last)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (state == ACC_LO && last && rd)
        lo <= sram.sram_dq_in;
      if (state == ACC_HI && last && rd)
        hi <= sram.sram_dq_in;
    end
  end

  // DONE always returns to IDLE so a still-held request is not replayed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = ACC_LO;
      ACC_LO:  if (last) state_nx = ACC_HI;
      ACC_HI:  if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sram.sram_addr   = '0;
    sram.sram_dq_out = '0;
    sram.sram_dq_oe  = 1'b0;
    sram.sram_we_n   = 1'b1;
    done             = 1'b0;
    case (state)
      ACC_LO: begin
        sram.sram_addr = lo_addr;
        if (wr) begin
          sram.sram_dq_out = wdata[15:0];
          sram.sram_dq_oe  = 1'b1;
          sram.sram_we_n   = 1'b0;
        end
      end
      ACC_HI: begin
        sram.sram_addr = hi_addr;
        if (wr) begin
          sram.sram_dq_out = wdata[31:16];
          sram.sram_dq_oe  = 1'b1;
          sram.sram_we_n   = 1'b0;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: maps byte address to SRAM half-words, stalls upstream, feeds WB.
// Ports: EXE-stage inputs, MEM/WB outputs, freeze, SRAM pin interface.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int SRAM_WAIT = SRAM_WAIT_DEF,
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int SRAM_AW   = SRAM_AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en_in,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      val_rm,
  input  logic [3:0]       dest_in,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic [31:0]      alu_result_out,
  output logic [31:0]      mem_data,
  output logic [3:0]       dest_out,
  output logic             freeze,
  mem_stage_sram_if.master sram
);

  logic               req;
  logic               wr;
  logic               done;
  logic [31:0]        off;
  logic [SRAM_AW-2:0] idx;
  logic               unused_off;

  assign req = mem_r_en | mem_w_en;
  // a simultaneous read and write request is treated as a read
  assign wr  = mem_w_en & ~mem_r_en;

  assign off        = alu_result - 32'(BASE_ADDR);
  assign idx        = off[SRAM_AW:2];
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

  mem_sram_fsm #(
    .SRAM_WAIT (SRAM_WAIT),
    .SRAM_AW   (SRAM_AW)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rd      (mem_r_en),
    .wr      (wr),
    .lo_addr ({idx, 1'b0}),
    .hi_addr ({idx, 1'b1}),
    .wdata   (val_rm),
    .rdata   (mem_data),
    .done    (done),
    .sram    (sram)
  );

  assign freeze         = req & ~done;
  assign wb_en_out      = wb_en_in & ~freeze;
  assign mem_r_en_out   = mem_r_en & ~freeze;
  assign alu_result_out = alu_result;
  assign dest_out       = dest_in;

endmodule
